parity_frame_controller: RTL and testbench
==========================================

// Module: parity_frame_controller
//
// PURPOSE
// Sequences serial bits into fixed-length frames (DATA_BITS data bits, LSB first,
// then 1 even-parity bit) and checks parity on the fly with a PAR/IMPAR running state.
// Presents each checked word downstream with a valid/ready handshake, a parity-error flag
// and saturating frame/error counters. Sits between a serial bit source and a word consumer.
//
// PARAMETERS
// DATA_BITS  8  data bits per frame (>=1); frame length = DATA_BITS+1
// CNT_W      8  width of frame_count and err_count (>=1)
//
// PORTS
// clk         in   1          clock, rising-edge
// reset       in   1          synchronous, active-high
// bit_valid   in   1          source presents bit_in this cycle
// bit_in      in   1          serial data/parity bit
// bit_ready   out  1          controller accepts a bit this cycle
// frame_abort in   1          discard the partially received frame
// data_out    out  DATA_BITS  received data word, bit0 = first bit received
// data_valid  out  1          data_out/parity_err valid
// out_ready   in   1          consumer accepts word
// parity_err  out  1          1 = odd total number of 1s (data+parity) in frame
// frame_count out  CNT_W      frames delivered, saturating
// err_count   out  CNT_W      frames delivered with parity_err=1, saturating
//
// BEHAVIOUR
// - Reset, synchronous, active-high: state=RX_DATA, bit index=0, parity state=PAR,
//   data_out=0, data_valid=0, parity_err=0, frame_count=0, err_count=0; bit_ready=1 next cycle.
// - Bit accepted iff bit_valid && bit_ready. bit_ready = 1 in RX_DATA, RX_PARITY; 0 in OUT_HOLD.
// - Parity state: PAR at frame start; toggles PAR<->IMPAR on every accepted 1 (data and parity bit).
// - FSM:
//   RX_DATA: accepted bit shifted into data_out[idx], idx++; after bit DATA_BITS-1 -> RX_PARITY.
//   RX_PARITY: accepted bit updates parity; -> OUT_HOLD; next cycle data_valid=1,
//     parity_err = (final parity state == IMPAR). Latency: 1 cycle after parity bit.
//   OUT_HOLD: data_out/parity_err held stable while data_valid=1 && !out_ready.
//     On data_valid && out_ready: data_valid=0 next cycle, counters update, parity->PAR, idx=0,
//     -> RX_DATA (bit_ready=1 the cycle after the handshake; no bit accepted in handshake cycle).
// - Counters: frame_count += 1 per handshake; err_count += 1 per handshake with parity_err=1;
//   both saturate at 2^CNT_W-1 (no wrap).
// - frame_abort in RX_DATA/RX_PARITY: idx=0, parity=PAR, -> RX_DATA; bit presented in same cycle
//   is dropped (abort wins). frame_abort in OUT_HOLD ignored (held word still delivered).
// - reset has priority over everything, including mid-frame and mid-handshake; counters cleared.
// - data_out bits not yet written in a frame retain old values until overwritten; undefined to consumer
//   only while data_valid=0.
// - Idle bit_valid=0 cycles mid-frame are allowed and do not advance idx.
//
// TESTING (DATA_BITS=8, CNT_W=2)
// 1. Bits of 0xA5 LSB first + parity 0, out_ready=1 -> data_out=0xA5, parity_err=0,
//    data_valid 1 cycle after parity bit; frame_count=1, err_count=0.
// 2. 0x01 + parity 0 -> parity_err=1, err_count=1; then 0x01 + parity 1 -> parity_err=0.
// 3. Backpressure: out_ready=0 for 5 cycles after frame 0x3C -> data_valid, data_out=0x3C held,
//    bit_ready=0, bit_valid pulses ignored; out_ready=1 -> one handshake, frame_count+1.
// 4. Abort after 4 bits, then full frame 0x0F + parity 0 -> only 0x0F delivered, parity_err=0.
// 5. Five erroneous frames -> err_count and frame_count saturate at 3.
// 6. reset after 5 bits, with bit_valid gaps -> all outputs at reset values; next full frame correct.

Source files
------------

// File: rtl/parity_frame_controller.sv
// Serial-to-word frame receiver: DATA_BITS data bits (LSB first) plus one even-parity
// bit, checked on the fly, delivered over valid/ready with saturating frame/error counters.
module parity_frame_controller #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 bit_ready,
  input  logic                 frame_abort,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {RX_DATA, RX_PARITY, OUT_HOLD} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             par_reg, par_next;      // 0 = PAR, 1 = IMPAR
  logic             perr_reg, perr_next;
  logic [CNT_W-1:0] fcnt_reg, fcnt_next;
  logic [CNT_W-1:0] ecnt_reg, ecnt_next;
  logic [DATA_BITS-1:0] data_reg;

  logic accept;
  logic handshake;
  logic data_wr;

  assign bit_ready   = (state_reg != OUT_HOLD);
  assign data_valid  = (state_reg == OUT_HOLD);
  assign accept      = bit_valid && bit_ready;
  assign handshake   = data_valid && out_ready;
  assign data_wr     = (state_reg == RX_DATA) && accept && !frame_abort;

  assign data_out    = data_reg;
  assign parity_err  = perr_reg;
  assign frame_count = fcnt_reg;
  assign err_count   = ecnt_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    par_next   = par_reg;
    perr_next  = perr_reg;
    fcnt_next  = fcnt_reg;
    ecnt_next  = ecnt_reg;
    case (state_reg)
      RX_DATA: begin
        if (frame_abort) begin
          idx_next = '0;
          par_next = 1'b0;
        end else if (accept) begin
          par_next = par_reg ^ bit_in;
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = RX_PARITY;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (frame_abort) begin
          idx_next   = '0;
          par_next   = 1'b0;
          state_next = RX_DATA;
        end else if (accept) begin
          par_next   = par_reg ^ bit_in;
          perr_next  = par_reg ^ bit_in;
          state_next = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        // abort is deliberately not looked at here: a completed word is always delivered
        if (handshake) begin
          idx_next   = '0;
          par_next   = 1'b0;
          state_next = RX_DATA;
          if (fcnt_reg != CNT_MAX) fcnt_next = fcnt_reg + 1'b1;
          if (perr_reg && (ecnt_reg != CNT_MAX)) ecnt_next = ecnt_reg + 1'b1;
        end
      end
      default: begin
        idx_next   = '0;
        par_next   = 1'b0;
        state_next = RX_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RX_DATA;
      idx_reg   <= '0;
      par_reg   <= 1'b0;
      perr_reg  <= 1'b0;
      fcnt_reg  <= '0;
      ecnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      par_reg   <= par_next;
      perr_reg  <= perr_next;
      fcnt_reg  <= fcnt_next;
      ecnt_reg  <= ecnt_next;
    end
  end

  // Each data bit only loads when its own index is being received; others keep old values.
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_data
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg[gi] <= 1'b0;
        end else if (data_wr && (idx_reg == IDX_W'(gi))) begin
          data_reg[gi] <= bit_in;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed bench for parity_frame_controller (DATA_BITS=8, CNT_W=2) with a word scoreboard.
module tb_parity_frame_controller;

  localparam int DB = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_valid;
  logic          bit_in;
  logic          bit_ready;
  logic          frame_abort;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          out_ready;
  logic          parity_err;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] err_count;

  int vectors = 0;
  int errors  = 0;
  logic [DB:0] sb[$];   // {parity_err, data}

  always #5 clk = ~clk;

  parity_frame_controller #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .frame_abort(frame_abort), .data_out(data_out),
    .data_valid(data_valid), .out_ready(out_ready), .parity_err(parity_err),
    .frame_count(frame_count), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are checked there or at the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    bit_valid = 1'b1;
    bit_in    = b;
    n = 0;
    while (!bit_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bit_ready) chk("bit_ready_timeout", {31'd0, bit_ready}, 32'd1);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    sb.push_back({(^d) ^ p, d});
    send_bit(p);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || data_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_counts(input string tag, input int fc, input int ec);
    chk({tag, "_fc"}, {30'd0, frame_count}, fc);
    chk({tag, "_ec"}, {30'd0, err_count}, ec);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // Scoreboard: every handshake must match the oldest pending word.
  always @(negedge clk) begin
    if (!reset && data_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL sb_unexpected: observed word %0h expected none", data_out);
      end else begin
        logic [DB:0] e;
        e = sb.pop_front();
        chk("sb_data", {24'd0, data_out}, {24'd0, e[DB-1:0]});
        chk("sb_perr", {31'd0, parity_err}, {31'd0, e[DB]});
        $display("word data=%02h perr=%0b exp=%02h/%0b", data_out, parity_err, e[DB-1:0], e[DB]);
      end
    end
  end

  initial begin
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; frame_abort = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_valid", {31'd0, data_valid}, 0);
    chk("rst_perr", {31'd0, parity_err}, 0);
    chk("rst_ready", {31'd0, bit_ready}, 1);
    chk_counts("rst", 0, 0);

    // 1: 0xA5 with correct parity, latency check
    for (int i = 0; i < DB; i++) send_bit(8'hA5 >> i);
    chk("t1_not_yet_valid", {31'd0, data_valid}, 0);
    sb.push_back({1'b0, 8'hA5});
    send_bit(1'b0);
    chk("t1_valid_latency", {31'd0, data_valid}, 1);
    wait_drain();
    chk_counts("t1", 1, 0);

    // 2: 0x01 with wrong parity, then correct parity
    send_frame(8'h01, 1'b0);
    wait_drain();
    chk_counts("t2a", 2, 1);
    send_frame(8'h01, 1'b1);
    wait_drain();
    chk_counts("t2b", 3, 1);

    // 3: backpressure, bit pulses and an abort during hold are ignored
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bit_valid   = c[0];
      bit_in      = 1'b1;
      frame_abort = (c == 2);
      chk("t3_valid", {31'd0, data_valid}, 1);
      chk("t3_hold", {24'd0, data_out}, 32'h3C);
      chk("t3_bit_ready", {31'd0, bit_ready}, 0);
      tick();
    end
    bit_valid = 1'b0; frame_abort = 1'b0;
    chk_counts("t3_held", 0, 0);
    out_ready = 1'b1;
    tick();
    chk("t3_released", {31'd0, data_valid}, 0);
    chk_counts("t3", 1, 0);
    chk("t3_ready_back", {31'd0, bit_ready}, 1);

    // 4: abort after 4 bits; abort wins over a bit in the same cycle
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bit_valid = 1'b1; bit_in = 1'b1; frame_abort = 1'b1;
    tick();
    bit_valid = 1'b0; frame_abort = 1'b0;
    send_frame(8'h0F, 1'b0);
    wait_drain();
    chk_counts("t4", 2, 0);

    // 5: five erroneous frames saturate both counters at 3
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h80 | k[7:0], ~(^(8'h80 | k[7:0])));
      wait_drain();
      chk_counts("t5", (k + 3 > 3) ? 3 : k + 3, (k + 1 > 3) ? 3 : k + 1);
    end

    // 6: reset mid-frame with idle gaps, then a clean frame
    for (int i = 0; i < 5; i++) begin
      send_bit(i[0]);
      tick();
    end
    do_reset();
    chk("t6_data", {24'd0, data_out}, 0);
    chk("t6_valid", {31'd0, data_valid}, 0);
    chk("t6_perr", {31'd0, parity_err}, 0);
    chk("t6_ready", {31'd0, bit_ready}, 1);
    chk_counts("t6_rst", 0, 0);
    send_frame(8'h5A, 1'b1);
    wait_drain();
    chk_counts("t6", 1, 1);
    send_frame(8'hC3, 1'b0);
    wait_drain();
    chk_counts("t6b", 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
